// File: rtl/wx_pkg.sv
// Shared types and defaults for the weight/input stream loader.
// Optional feature macro used by the top: WX_LOADER_CHECKSUM_EN.
package wx_pkg;

  localparam int W_ADDR_LEN_DEF = 32'd20;
  localparam int X_ADDR_LEN_DEF = 32'd10;
  localparam int W0_DEPTH_DEF   = 32'd6;
  localparam int W1_DEPTH_DEF   = 32'd9;
  localparam int W2_DEPTH_DEF   = 32'd9;
  localparam int W3_DEPTH_DEF   = 32'd9;
  localparam int X_DEPTH_DEF    = 32'd2;
  localparam int SEL_W          = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_X  = 3'd2,
    ST_HANDOFF = 3'd3,
    ST_COMPUTE = 3'd4,
    ST_FIN     = 3'd5
  } wx_state_t;

  function automatic int max_len(input int a, input int b);
    if (a > b) return a;
    else return b;
  endfunction

endpackage

// File: rtl/wx_bank_counter.sv
// Element counter for one memory bank; wraps to zero on the accepted last element.
module wx_bank_counter
  import wx_pkg::*;
#(
  parameter int CNT_W = W_ADDR_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] depth,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_r;

  assign last  = (count_r == (depth - CNT_W'(1'b1)));
  assign count = count_r;

  // Count accepted elements, clearing on a new run or at the bank boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      if (last) count_r <= '0;
      else      count_r <= count_r + CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/wx_loader.sv
// Serial loader: streams bits into four weight banks and one input bank, then hands
// the memories to compute. Define WX_LOADER_CHECKSUM_EN to add a count-of-ones output.
module wx_loader
  import wx_pkg::*;
#(
  parameter int W_ADDR_LEN = W_ADDR_LEN_DEF,
  parameter int X_ADDR_LEN = X_ADDR_LEN_DEF,
  parameter int W0_DEPTH   = W0_DEPTH_DEF,
  parameter int W1_DEPTH   = W1_DEPTH_DEF,
  parameter int W2_DEPTH   = W2_DEPTH_DEF,
  parameter int W3_DEPTH   = W3_DEPTH_DEF,
  parameter int X_DEPTH    = X_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_data,
  output logic                  in_ready,
  output logic                  w_wq,
  output logic [SEL_W-1:0]      w_sel,
  output logic [W_ADDR_LEN-1:0] w_addr,
  output logic                  x_wq,
  output logic [SEL_W-1:0]      x_sel,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic                  wx_write,
  output logic                  load_compute_ctrl,
  output logic                  en_compute,
  input  logic                  compute_finish,
  output logic                  busy,
  output logic                  done
`ifdef WX_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]           checksum
`endif
);

  localparam int CNT_W = max_len(W_ADDR_LEN, X_ADDR_LEN);

  wx_state_t              state_r, next_s;
  logic [SEL_W-1:0]       bank_r, w_sel_r;
  logic [CNT_W-1:0]       count_s, depth_s;
  logic [W_ADDR_LEN-1:0]  w_addr_r;
  logic [X_ADDR_LEN-1:0]  x_addr_r;
  logic                   load_w_s, load_x_s, accept_s, start_s, last_s;
  logic                   w_wq_r, x_wq_r, wx_write_r;
  logic                   lcc_r, en_compute_r, busy_r, done_r;

  assign load_w_s = (state_r == ST_LOAD_W);
  assign load_x_s = (state_r == ST_LOAD_X);
  assign in_ready = load_w_s | load_x_s;
  assign accept_s = in_valid & in_ready;
  assign start_s  = start & (state_r == ST_IDLE);

  // Depth of the bank currently being filled.
  always_comb begin
    depth_s = CNT_W'(X_DEPTH);
    if (load_w_s) begin
      case (bank_r)
        2'd0:    depth_s = CNT_W'(W0_DEPTH);
        2'd1:    depth_s = CNT_W'(W1_DEPTH);
        2'd2:    depth_s = CNT_W'(W2_DEPTH);
        2'd3:    depth_s = CNT_W'(W3_DEPTH);
        default: depth_s = CNT_W'(W0_DEPTH);
      endcase
    end else begin
      depth_s = CNT_W'(X_DEPTH);
    end
  end

  wx_bank_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_s),
    .inc   (accept_s),
    .depth (depth_s),
    .count (count_s),
    .last  (last_s)
  );

  // Next-state decode.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:    if (start) next_s = ST_LOAD_W; else next_s = ST_IDLE;
      ST_LOAD_W:  if (accept_s && last_s && (bank_r == 2'd3)) next_s = ST_LOAD_X;
                  else next_s = ST_LOAD_W;
      ST_LOAD_X:  if (accept_s && last_s) next_s = ST_HANDOFF; else next_s = ST_LOAD_X;
      ST_HANDOFF: next_s = ST_COMPUTE;
      ST_COMPUTE: if (compute_finish) next_s = ST_FIN; else next_s = ST_COMPUTE;
      ST_FIN:     next_s = ST_IDLE;
      default:    next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= ST_IDLE;
    else      state_r <= next_s;
  end

  // Bank tracker; w_sel trails it by a cycle so the final write keeps the old bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_r  <= 2'd0;
      w_sel_r <= 2'd0;
    end else if (start_s) begin
      bank_r  <= 2'd0;
      w_sel_r <= 2'd0;
    end else begin
      w_sel_r <= bank_r;
      if (accept_s && load_w_s && last_s && (bank_r != 2'd3)) bank_r <= bank_r + 2'd1;
      else bank_r <= bank_r;
    end
  end

  // Registered write port; address and data hold when no bit is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_wq_r     <= 1'b0;
      x_wq_r     <= 1'b0;
      w_addr_r   <= '0;
      x_addr_r   <= '0;
      wx_write_r <= 1'b0;
    end else begin
      w_wq_r <= accept_s & load_w_s;
      x_wq_r <= accept_s & load_x_s;
      if (accept_s) begin
        wx_write_r <= in_data;
        if (load_w_s) w_addr_r <= W_ADDR_LEN'(count_s);
        else          x_addr_r <= X_ADDR_LEN'(count_s);
      end else begin
        wx_write_r <= wx_write_r;
      end
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcc_r        <= 1'b1;
      en_compute_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      lcc_r        <= !((next_s == ST_HANDOFF) || (next_s == ST_COMPUTE));
      en_compute_r <= (next_s == ST_COMPUTE);
      busy_r       <= (next_s != ST_IDLE);
      done_r       <= (next_s == ST_FIN);
    end
  end

`ifdef WX_LOADER_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Count of accepted one-bits for the current run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      checksum_r <= 16'd0;
    else if (start_s)              checksum_r <= 16'd0;
    else if (accept_s && in_data)  checksum_r <= checksum_r + 16'd1;
    else                           checksum_r <= checksum_r;
  end

  assign checksum = checksum_r;
`endif

  assign w_wq              = w_wq_r;
  assign x_wq              = x_wq_r;
  assign w_sel             = w_sel_r;
  assign x_sel             = 2'd0;
  assign w_addr            = w_addr_r;
  assign x_addr            = x_addr_r;
  assign wx_write          = wx_write_r;
  assign load_compute_ctrl = lcc_r;
  assign en_compute        = en_compute_r;
  assign busy              = busy_r;
  assign done              = done_r;

endmodule

// File: tb/tb_wx_loader.sv
// Self-checking bench for wx_loader: random streams against a bank-layout reference model.
module tb_wx_loader;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0, in_data = 1'b0;
  logic        compute_finish = 1'b0;
  logic        in_ready, w_wq, x_wq, wx_write, load_compute_ctrl, en_compute, busy, done;
  logic [1:0]  w_sel, x_sel;
  logic [19:0] w_addr;
  logic [9:0]  x_addr;
`ifdef WX_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0, failures = 0;
  bit stream[35];
  int ones = 0;
  int depths[5] = '{6, 9, 9, 9, 2};

  wx_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w_wq(w_wq), .w_sel(w_sel), .w_addr(w_addr),
    .x_wq(x_wq), .x_sel(x_sel), .x_addr(x_addr), .wx_write(wx_write),
    .load_compute_ctrl(load_compute_ctrl), .en_compute(en_compute),
    .compute_finish(compute_finish), .busy(busy), .done(done)
`ifdef WX_LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Reference: stream index -> (memory, bank, address) from the bank depths.
  function automatic void exp_loc(input int idx, output bit is_x, output int sel, output int addr);
    int r = idx;
    is_x = 1'b0; sel = 0; addr = 0;
    for (int b = 0; b < 5; b++) begin
      if (r < depths[b]) begin
        is_x = (b == 4); sel = (b < 4) ? b : 0; addr = r;
        return;
      end
      r -= depths[b];
    end
  endfunction

  // mode 0: random bits, 1: all ones, 2: exactly 20 ones in random positions
  task automatic fill_stream(input int mode);
    ones = 0;
    for (int i = 0; i < 35; i++)
      stream[i] = (mode == 1) ? 1'b1 : (mode == 2) ? (i < 20) : 1'($urandom_range(1));
    if (mode == 2) begin
      for (int i = 34; i > 0; i--) begin
        int j = $urandom_range(i);
        bit t = stream[i]; stream[i] = stream[j]; stream[j] = t;
      end
    end
    for (int i = 0; i < 35; i++) ones += stream[i];
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({in_ready, w_wq, w_sel, w_addr, x_wq, x_sel, x_addr, wx_write,
         load_compute_ctrl, en_compute, busy, done} !==
        {1'b0, 1'b0, 2'd0, 20'd0, 1'b0, 2'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s actual rdy=%b wq=%b sel=%0d wa=%0d xq=%b xs=%0d xa=%0d d=%b lcc=%b en=%b busy=%b done=%b required all zero except lcc=1",
               tag, in_ready, w_wq, w_sel, w_addr, x_wq, x_sel, x_addr, wx_write,
               load_compute_ctrl, en_compute, busy, done);
    end
`ifdef WX_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'd0) begin
      failures++; $display("FAIL %s_checksum actual=%0d required=0", tag, checksum);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    check_reset_values("reset_state");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic start_run();
    start = 1'b1; in_valid = 1'b0; compute_finish = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, in_ready, w_sel, w_wq} !== {1'b1, 1'b1, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL start actual busy=%b rdy=%b sel=%0d wq=%b required 1 1 0 0", busy, in_ready, w_sel, w_wq);
    end
`ifdef WX_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'd0) begin
      failures++; $display("FAIL start_checksum actual=%0d required=0", checksum);
    end
`endif
  endtask

  // Stream bits with random valid gaps plus a forced 3-cycle gap after gap_at bits;
  // start and compute_finish are toggled randomly and must be ignored.
  task automatic load_stream(input int gap_at, input int gap_pct, input int stop_after);
    int  acc = 0, cyc = 0, gap_left = 0, sel, addr, ewa = 0, exa = 0;
    bit  cur, is_x, have_w = 0, have_x = 0, have_d = 0, exp_d = 0;
    while (acc < stop_after && cyc < 3000) begin
      in_valid = (gap_left == 0) && ($urandom_range(99) >= gap_pct);
      if (gap_left > 0) gap_left--;
      in_data = stream[acc];
      start = 1'($urandom_range(1));
      compute_finish = 1'($urandom_range(1));
      cur = in_valid;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL in_ready idx=%0d actual=%b required=1", acc, in_ready);
      end
      @(posedge clk); #1;
      cyc++;
      if (cur) begin
        exp_loc(acc, is_x, sel, addr);
        checks++;
        if ({w_wq, x_wq, wx_write} !== {!is_x, is_x, stream[acc]}) begin
          failures++;
          $display("FAIL write idx=%0d actual wq=%b xq=%b data=%b required %b %b %b",
                   acc, w_wq, x_wq, wx_write, !is_x, is_x, stream[acc]);
        end
        checks++;
        if (!is_x && (w_sel !== 2'(sel) || w_addr !== 20'(addr))) begin
          failures++;
          $display("FAIL w_loc idx=%0d actual sel=%0d addr=%0d required sel=%0d addr=%0d", acc, w_sel, w_addr, sel, addr);
        end else if (is_x && (x_sel !== 2'd0 || x_addr !== 10'(addr))) begin
          failures++;
          $display("FAIL x_loc idx=%0d actual sel=%0d addr=%0d required sel=0 addr=%0d", acc, x_sel, x_addr, addr);
        end
        if (is_x) begin have_x = 1; exa = addr; end
        else begin have_w = 1; ewa = addr; end
        have_d = 1; exp_d = stream[acc];
        acc++;
        if (acc == gap_at) gap_left = 3;
      end else begin
        checks++;
        if ({w_wq, x_wq} !== 2'b00) begin
          failures++; $display("FAIL idle_we idx=%0d actual wq=%b xq=%b required 0 0", acc, w_wq, x_wq);
        end
        checks++;
        if ((have_w && w_addr !== 20'(ewa)) || (have_x && x_addr !== 10'(exa)) ||
            (have_d && wx_write !== exp_d)) begin
          failures++;
          $display("FAIL hold idx=%0d actual wa=%0d xa=%0d d=%b required wa=%0d xa=%0d d=%b",
                   acc, w_addr, x_addr, wx_write, ewa, exa, exp_d);
        end
      end
    end
    start = 1'b0; in_valid = 1'b0; compute_finish = 1'b0;
    checks++;
    if (acc < stop_after) begin
      failures++; $display("FAIL load_timeout actual=%0d required=%0d", acc, stop_after);
    end
    if (stop_after == 35) begin
      checks++;
      if ({load_compute_ctrl, en_compute, busy, in_ready} !== 4'b0010) begin
        failures++;
        $display("FAIL handoff actual lcc=%b en=%b busy=%b rdy=%b required 0 0 1 0",
                 load_compute_ctrl, en_compute, busy, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if ({load_compute_ctrl, en_compute, busy, done} !== 4'b0110) begin
        failures++;
        $display("FAIL compute_entry actual lcc=%b en=%b busy=%b done=%b required 0 1 1 0",
                 load_compute_ctrl, en_compute, busy, done);
      end
    end
  endtask

  task automatic test_compute();
    int wait_n = $urandom_range(5);
    repeat (wait_n) begin
      start = 1'($urandom_range(1));
      @(posedge clk); #1;
      checks++;
      if ({en_compute, load_compute_ctrl, done} !== 3'b100) begin
        failures++;
        $display("FAIL compute_wait actual en=%b lcc=%b done=%b required 1 0 0", en_compute, load_compute_ctrl, done);
      end
    end
    start = 1'b0; compute_finish = 1'b1;
    @(posedge clk); #1;
    compute_finish = 1'b0;
    checks++;
    if ({done, load_compute_ctrl, en_compute, busy} !== 4'b1101) begin
      failures++;
      $display("FAIL fin actual done=%b lcc=%b en=%b busy=%b required 1 1 0 1", done, load_compute_ctrl, en_compute, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, busy, load_compute_ctrl, in_ready, w_wq} !== 5'b00100) begin
      failures++;
      $display("FAIL idle_after actual done=%b busy=%b lcc=%b rdy=%b wq=%b required 0 0 1 0 0",
               done, busy, load_compute_ctrl, in_ready, w_wq);
    end
`ifdef WX_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 16'(ones)) begin
      failures++; $display("FAIL checksum actual=%0d required=%0d", checksum, ones);
    end
`endif
  endtask

  task automatic test_all_ones();
    fill_stream(1);
    start_run();
    load_stream(-1, 0, 35);
    test_compute();
  endtask

  task automatic test_pattern_gap();
    fill_stream(0);
    stream[0] = 1; stream[1] = 0; stream[2] = 1; stream[3] = 1; stream[4] = 0; stream[5] = 0;
    ones = 0;
    for (int i = 0; i < 35; i++) ones += stream[i];
    start_run();
    load_stream(5, 0, 35);
    test_compute();
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      fill_stream(0);
      start_run();
      load_stream($urandom_range(34), 35, 35);
      test_compute();
    end
  endtask

  task automatic test_reset_mid();
    fill_stream(0);
    start_run();
    load_stream(-1, 20, 20);
    checks++;
    if ({w_sel, w_addr} !== {2'd2, 20'd4}) begin
      failures++; $display("FAIL pre_reset actual sel=%0d addr=%0d required sel=2 addr=4", w_sel, w_addr);
    end
    in_valid = 1'b1;
    rst = 1'b0;
    #1;
    check_reset_values("reset_mid");
    @(posedge clk); #1;
    checks++;
    if ({w_wq, x_wq, busy} !== 3'b000) begin
      failures++; $display("FAIL reset_hold actual wq=%b xq=%b busy=%b required 0 0 0", w_wq, x_wq, busy);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    fill_stream(0);
    start_run();
    load_stream(-1, 25, 35);
    test_compute();
  endtask

  task automatic test_checksum20();
    fill_stream(2);
    start_run();
    load_stream(-1, 15, 35);
    test_compute();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_pattern_gap();
    test_random_runs();
    test_reset_mid();
    test_checksum20();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
